// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the single-outstanding imem request,
// and presents pc/inst/fetch-exception info to the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hazard_stall,
  input  logic        exe_stall,
  input  logic        cond_exe_stall,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        int_flush,
  input  logic [31:0] int_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        cp0_ex,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_badvaddr
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DROP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic        redir_pend_q, redir_pend_d;

  logic stall_s, misalign_s, out_valid_s, consume_s, fetch_ok_s;

  // Stall merge, alignment check and delivery qualification
  always_comb begin
    stall_s    = hazard_stall | exe_stall | cond_exe_stall;
    misalign_s = (pc_q[1:0] != 2'b00);
    fetch_ok_s = (state_q == FETCH) && !misalign_s;
    case (state_q)
      FETCH:   out_valid_s = misalign_s | imem_ack;
      HOLD:    out_valid_s = 1'b1;
      default: out_valid_s = 1'b0;
    endcase
    consume_s = out_valid_s & ~stall_s;
  end

  // Next-state: flush > consume > delay-slot capture / stall hold / drop drain
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_inst_d  = hold_inst_q;
    redir_tgt_d  = redir_tgt_q;
    redir_pend_d = redir_pend_q;
    req_addr_d   = (state_q == FETCH) ? pc_q : req_addr_q;

    if (int_flush) begin
      pc_d         = int_target;
      redir_pend_d = 1'b0;
      // An issued request cannot be cancelled; drain it before refetching
      if ((fetch_ok_s || (state_q == DROP)) && !imem_ack) begin
        state_d = DROP;
      end else begin
        state_d = FETCH;
      end
    end else if (consume_s) begin
      if (jmp) begin
        pc_d = jmp_target;
      end else if (redir_pend_q) begin
        pc_d = redir_tgt_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
      redir_pend_d = 1'b0;
      state_d      = FETCH;
    end else begin
      if (jmp) begin
        redir_pend_d = 1'b1;
        redir_tgt_d  = jmp_target;
      end else begin
        redir_pend_d = redir_pend_q;
      end
      case (state_q)
        FETCH: begin
          // A misaligned fault is regenerated each cycle, so only real data needs holding
          if (out_valid_s && stall_s && !misalign_s) begin
            hold_inst_d = imem_rdata;
            state_d     = HOLD;
          end else begin
            state_d = FETCH;
          end
        end
        DROP:    state_d = imem_ack ? FETCH : DROP;
        default: state_d = state_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_inst_q  <= 32'd0;
      redir_tgt_q  <= 32'd0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_inst_q  <= hold_inst_d;
      redir_tgt_q  <= redir_tgt_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  // Output decode; everything forced to zero while in reset
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = 32'd0;
    pc           = 32'd0;
    inst         = 32'd0;
    cp0_ex       = 1'b0;
    cp0_excode   = 5'd0;
    cp0_badvaddr = 32'd0;
    if (resetn) begin
      if (state_q == DROP) begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end else if (fetch_ok_s) begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end else begin
        imem_req  = 1'b0;
      end
      if (out_valid_s) begin
        pc = pc_q;
        if (state_q == HOLD) begin
          inst = hold_inst_q;
        end else if (misalign_s) begin
          cp0_ex       = 1'b1;
          cp0_excode   = 5'h04;
          cp0_badvaddr = pc_q;
        end else begin
          inst = imem_rdata;
        end
      end else begin
        pc = 32'd0;
      end
    end else begin
      imem_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs driven 1 time unit after the rising edge,
// outputs sampled on the falling edge against hand-computed values.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        resetn, hazard_stall, exe_stall, cond_exe_stall, jmp, int_flush, imem_ack;
  logic [31:0] jmp_target, int_target, imem_rdata;
  logic        imem_req, cp0_ex;
  logic [31:0] imem_addr, pc, inst, cp0_badvaddr;
  logic [4:0]  cp0_excode;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch #(.RESET_PC(32'hBFC00000)) dut (
    .clk(clk), .resetn(resetn),
    .hazard_stall(hazard_stall), .exe_stall(exe_stall), .cond_exe_stall(cond_exe_stall),
    .jmp(jmp), .jmp_target(jmp_target), .int_flush(int_flush), .int_target(int_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc(pc), .inst(inst), .cp0_ex(cp0_ex), .cp0_excode(cp0_excode), .cp0_badvaddr(cp0_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive after the edge, settle to the falling edge
  task automatic step(input logic rn, input logic ack, input logic [31:0] rd,
                      input logic hz, input logic cs, input logic jp, input logic [31:0] jt,
                      input logic fl, input logic [31:0] ft);
    @(posedge clk);
    #1;
    resetn = rn; imem_ack = ack; imem_rdata = rd;
    hazard_stall = hz; exe_stall = 1'b0; cond_exe_stall = cs;
    jmp = jp; jmp_target = jt; int_flush = fl; int_target = ft;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic [31:0] epc, input logic [31:0] einst);
    chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".pc"},   pc, epc);
    chk({tag, ".inst"}, inst, einst);
  endtask

  task automatic expect_ex(input string tag, input logic ex, input logic [31:0] bad);
    chk({tag, ".ex"},   {31'd0, cp0_ex}, {31'd0, ex});
    chk({tag, ".code"}, {27'd0, cp0_excode}, ex ? 32'h4 : 32'h0);
    chk({tag, ".bad"},  cp0_badvaddr, bad);
  endtask

  initial begin
    resetn = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; hazard_stall = 1'b0;
    exe_stall = 1'b0; cond_exe_stall = 1'b0; jmp = 1'b0; jmp_target = 32'd0;
    int_flush = 1'b0; int_target = 32'd0;

    // Reset: outputs forced to zero even with ack/data present
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("rst0", 1'b0, 32'd0, 32'd0, 32'd0);
    expect_ex("rst0", 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("rst1", 1'b0, 32'd0, 32'd0, 32'd0);

    // Zero-wait streaming
    step(1'b1, 1'b1, 32'h24080001, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("s1", 1'b1, 32'hBFC00000, 32'hBFC00000, 32'h24080001);
    expect_ex("s1", 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h24090002, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("s2", 1'b1, 32'hBFC00004, 32'hBFC00004, 32'h24090002);
    step(1'b1, 1'b1, 32'h240A0003, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("s3", 1'b1, 32'hBFC00008, 32'hBFC00008, 32'h240A0003);

    // Two wait states: address stable, bubbles delivered
    step(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("w1", 1'b1, 32'hBFC0000C, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("w2", 1'b1, 32'hBFC0000C, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h8C010000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("w3", 1'b1, 32'hBFC0000C, 32'hBFC0000C, 32'h8C010000);

    // Jump in the same cycle its delay slot is consumed
    step(1'b1, 1'b1, 32'h08000040, 1'b0, 1'b0, 1'b1, 32'hBFC00100, 1'b0, 32'd0);
    expect_out("j1", 1'b1, 32'hBFC00010, 32'hBFC00010, 32'h08000040);
    step(1'b1, 1'b1, 32'h20420001, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("j2", 1'b1, 32'hBFC00100, 32'hBFC00100, 32'h20420001);

    // Jump while the delay-slot fetch is pending: slot first, then target
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hBFC00200, 1'b0, 32'd0);
    expect_out("d1", 1'b1, 32'hBFC00104, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h00851020, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("d2", 1'b1, 32'hBFC00104, 32'hBFC00104, 32'h00851020);
    step(1'b1, 1'b1, 32'h3C1D8000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("d3", 1'b1, 32'hBFC00200, 32'hBFC00200, 32'h3C1D8000);

    // Hazard stall for 3 cycles, acked on the first
    step(1'b1, 1'b1, 32'hAC220004, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("h1", 1'b1, 32'hBFC00204, 32'hBFC00204, 32'hAC220004);
    step(1'b1, 1'b1, 32'h99999999, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("h2", 1'b0, 32'd0, 32'hBFC00204, 32'hAC220004);
    step(1'b1, 1'b0, 32'h99999999, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("h3", 1'b0, 32'd0, 32'hBFC00204, 32'hAC220004);
    step(1'b1, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("h4", 1'b0, 32'd0, 32'hBFC00204, 32'hAC220004);
    step(1'b1, 1'b1, 32'h8FA40010, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("h5", 1'b1, 32'hBFC00208, 32'hBFC00208, 32'h8FA40010);

    // Conditional-exec stall takes the same hold path
    step(1'b1, 1'b1, 32'h14400003, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("c1", 1'b1, 32'hBFC0020C, 32'hBFC0020C, 32'h14400003);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("c2", 1'b0, 32'd0, 32'hBFC0020C, 32'h14400003);

    // Flush during an outstanding fetch: drain old address, discard data
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("f1", 1'b1, 32'hBFC00210, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00380);
    expect_out("f2", 1'b1, 32'hBFC00210, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'hBADBAD00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("f3", 1'b1, 32'hBFC00210, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'hBADBAD00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("f4", 1'b1, 32'hBFC00210, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h42000018, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("f5", 1'b1, 32'hBFC00380, 32'hBFC00380, 32'h42000018);

    // Jump to a misaligned target raises AdEL at fetch
    step(1'b1, 1'b1, 32'h08000041, 1'b0, 1'b0, 1'b1, 32'hBFC00102, 1'b0, 32'd0);
    expect_out("m1", 1'b1, 32'hBFC00384, 32'hBFC00384, 32'h08000041);
    step(1'b1, 1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("m2", 1'b0, 32'd0, 32'hBFC00102, 32'd0);
    expect_ex("m2", 1'b1, 32'hBFC00102);
    // Flush from misaligned PC goes straight to FETCH; concurrent jmp ignored
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hBFC00500, 1'b1, 32'hBFC00400);
    expect_out("m3", 1'b0, 32'd0, 32'hBFC00106, 32'd0);
    expect_ex("m3", 1'b1, 32'hBFC00106);
    step(1'b1, 1'b1, 32'h00000021, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("m4", 1'b1, 32'hBFC00400, 32'hBFC00400, 32'h00000021);
    expect_ex("m4", 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h00000025, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("m5", 1'b1, 32'hBFC00404, 32'hBFC00404, 32'h00000025);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: owns the PC and drives the instruction-memory request/ack interface.
- Presents pc, inst and fetch-exception info to the IF/ID pipeline register for capture.
- Handles branch/jump redirect with one delay slot, exception/ERET redirect (int_flush), pipeline stalls, memory wait states, misaligned-PC detection (AdEL).

Parameters:
RESET_PC, 32'hBFC00000, PC loaded at reset.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
hazard_stall  in  1  decode hazard stall; hold current instruction
exe_stall  in  1  execute multi-cycle stall; hold
cond_exe_stall  in  1  conditional-exec stall; hold (IF/ID inserts bubble)
jmp  in  1  taken branch/jump in decode this cycle
jmp_target  in  32  branch/jump target
int_flush  in  1  exception/ERET flush; highest priority
int_target  in  32  exception vector or EPC
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word-aligned)
imem_rdata  in  32  instruction data, valid when imem_ack
imem_ack  in  1  request complete this cycle
pc  out  32  PC of delivered instruction (0 when no valid)
inst  out  32  delivered instruction (0 = bubble)
cp0_ex  out  1  delivered instruction has fetch exception
cp0_excode  out  5  5'h04 (AdEL) when cp0_ex, else 0
cp0_badvaddr  out  32  faulting PC when cp0_ex, else 0

Behaviour:
- Resetn is synchronous and active-low; clock is clk.
- Registers: pc_reg, req_addr, hold_inst, redir_pend, redir_tgt, state in {FETCH, HOLD, DROP}.
- Reset: pc_reg=RESET_PC, state=FETCH, redir_pend=0, hold_inst=0.
- While resetn=0, all outputs are forced to 0.
- stall = hazard_stall | exe_stall | cond_exe_stall.
- misalign = pc_reg[1:0] != 0.
- FETCH, aligned:
  - imem_req=1, imem_addr=pc_reg. req_addr tracks pc_reg.
  - Once issued, the request is held at the same address until imem_ack.
  - out_valid = imem_ack, with inst = imem_rdata passed through combinationally. Zero-wait memory therefore sustains 1 instruction/cycle.
- FETCH, misaligned:
  - imem_req=0.
  - out_valid=1 immediately: inst=0, cp0_ex=1, excode=5'h04, badvaddr=pc_reg.
- HOLD:
  - imem_req=0. out_valid=1 with inst=hold_inst.
- out_valid=0: pc, inst, cp0_ex, excode and badvaddr are all 0. IF/ID then latches a NOP bubble.
- consume = out_valid & ~stall. On consume:
  - pc_reg <= jmp ? jmp_target : redir_pend ? redir_tgt : pc_reg+4 (32-bit wrap);
  - redir_pend <= 0;
  - state <= FETCH.
- out_valid & stall in FETCH: hold_inst <= imem_rdata; state <= HOLD.
- Delay slot: jmp without consume sets redir_pend=1 and redir_tgt=jmp_target (a repeated jmp overwrites). The next consumed instruction is the sequential one; the instruction after it is at the target.
- int_flush overrides everything, including stall:
  - pc_reg <= int_target; redir_pend <= 0; any output is discarded.
  - If the current state is FETCH or DROP with an aligned request outstanding and imem_ack=0: state <= DROP. Otherwise state <= FETCH.
- DROP:
  - imem_req=1, imem_addr=req_addr (old address), out_valid=0.
  - On imem_ack, data is discarded and state <= FETCH.
  - int_flush during DROP updates pc_reg only.
- jmp is ignored in any cycle with int_flush.
- Misaligned jmp_target or int_target is accepted; the fault is raised at fetch.
- At most one outstanding request. imem_addr must be stable while imem_req=1 and imem_ack=0.

Test Plan:
1. Reset, zero-wait ack, no stalls -> imem_addr BFC00000, BFC00004, BFC00008 on consecutive cycles; pc/inst pass through each cycle.
2. imem_ack delayed 2 cycles at BFC00004 -> imem_addr stable 3 cycles; pc=inst=0 for 2 cycles; then pc=BFC00004 delivered.
3. jmp=1, jmp_target=BFC00100 while pc=BFC00004 is consumed -> next delivered pc=BFC00100. Same jmp while the BFC00004 fetch is pending -> BFC00004 (delay slot) delivered, then BFC00100.
4. hazard_stall held 3 cycles with ack on the first -> pc/inst held via HOLD with imem_req=0. Release -> next fetch BFC00008.
5. int_flush, int_target=BFC00380, during an outstanding unacked fetch -> DROP holds the old address until ack, data discarded; next imem_addr=BFC00380; no stale instruction delivered.
6. jmp_target=BFC00102 -> imem_req=0; delivered pc=BFC00102, inst=0, cp0_ex=1, excode=04, badvaddr=BFC00102.
